// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: serial sequencer state encoding and width limits.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } serial_add_state_t;

    localparam int SERIAL_ADD_WIDTH_DEF = 8;
    localparam int SERIAL_ADD_WIDTH_MAX = 64;

endpackage

// File: rtl/f_adder1.sv
// 1-bit full-adder cell; the shared bit datapath of the serial adder.
module f_adder1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder cell stepped LSB first over WIDTH cycles, start/busy/done handshake.
// Optional signed-overflow output enabled by SERIAL_ADD_OVF_EN.
module serial_add_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    serial_add_state_t state;
    logic [WIDTH-1:0]  sa, sb;
    logic [WIDTH-2:0]  acc;
    logic              c_r;
    logic [CW-1:0]     cnt;
    logic              bit_s, bit_c;
    logic              last;
    logic [WIDTH-1:0]  acc_shift;

    f_adder1 u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (c_r),
        .s  (bit_s),
        .co (bit_c)
    );

    assign last      = (cnt == CW'(WIDTH - 1));
    // acc holds the low WIDTH-1 result bits; the final bit goes straight into sum.
    assign acc_shift = {bit_s, acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            c_r   <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        c_r   <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    acc <= acc_shift[WIDTH-1:1];
                    c_r <= bit_c;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        sum   <= acc_shift;
                        cout  <= bit_c;
`ifdef SERIAL_ADD_OVF_EN
                        // c_r is the carry into the MSB, bit_c the carry out of it
                        ovf   <= c_r ^ bit_c;
`endif
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq at WIDTH 8, 2 and 64 against an arithmetic reference.
module tb_serial_add_seq;

    logic clk, rst_n;

    logic        st8, ci8, busy8, done8, co8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        st2, ci2, busy2, done2, co2, ovf2;
    logic [1:0]  a2, b2, sum2;
    logic        st64, ci64, busy64, done64, co64, ovf64;
    logic [63:0] a64, b64, sum64;

    int checks = 0;
    int errors = 0;

    serial_add_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(co8)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf8)
`endif
    );
    serial_add_seq #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .cin(ci2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(co2)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf2)
`endif
    );
    serial_add_seq #(.WIDTH(64)) u64 (
        .clk(clk), .rst_n(rst_n), .start(st64), .a(a64), .b(b64), .cin(ci64),
        .busy(busy64), .done(done64), .sum(sum64), .cout(co64)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf64)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf8  = 1'b0;
    assign ovf2  = 1'b0;
    assign ovf64 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [63:0] av, input logic [63:0] bv,
                         input logic c);
        case (w)
            8:       begin st8 = s;  a8 = av[7:0];  b8 = bv[7:0];  ci8 = c;  end
            2:       begin st2 = s;  a2 = av[1:0];  b2 = bv[1:0];  ci2 = c;  end
            default: begin st64 = s; a64 = av;      b64 = bv;      ci64 = c; end
        endcase
    endtask

    task automatic get(input int w, output logic bsy, output logic dn, output logic [63:0] s,
                       output logic co, output logic ov);
        case (w)
            8:       begin bsy = busy8;  dn = done8;  s = {56'b0, sum8}; co = co8;  ov = ovf8;  end
            2:       begin bsy = busy2;  dn = done2;  s = {62'b0, sum2}; co = co2;  ov = ovf2;  end
            default: begin bsy = busy64; dn = done64; s = sum64;         co = co64; ov = ovf64; end
        endcase
    endtask

    // Reference: plain (WIDTH+1)-bit addition; signed overflow from operand/result sign bits.
    task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv, input logic c,
                         output logic [63:0] es, output logic eco, output logic eov);
        logic [63:0] mask;
        logic [64:0] tot;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        tot  = {1'b0, av & mask} + {1'b0, bv & mask} + {64'b0, c};
        es   = tot[63:0] & mask;
        eco  = tot[w];
        eov  = (av[w-1] == bv[w-1]) && (es[w-1] != av[w-1]);
    endtask

    // One full operation; optionally pulses start with new operands mid-run.
    task automatic op(input int w, input logic [63:0] av, input logic [63:0] bv, input logic c,
                      input bit disturb);
        logic bsy, dn, co, ov, eco, eov;
        logic [63:0] s, es;
        int n;
        model(w, av, bv, c, es, eco, eov);
        @(negedge clk);
        drive(w, 1'b1, av, bv, c);
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            if (n == 0) drive(w, 1'b0, av, bv, c);
            get(w, bsy, dn, s, co, ov);
            if (dn || n > w + 3) break;
            chk("busy_run", {64'b0, bsy}, 65'd1);
            if (disturb && n == 3) drive(w, 1'b1, ~av, av ^ bv, ~c);
            if (disturb && n == 4) drive(w, 1'b0, ~av, av ^ bv, ~c);
            @(posedge clk);
            n++;
        end
        chk("latency", 65'(n), 65'(w));
        chk("done", {64'b0, dn}, 65'd1);
        chk("busy_done", {64'b0, bsy}, 65'd0);
        chk("sum", {1'b0, s}, {1'b0, es});
        chk("cout", {64'b0, co}, {64'b0, eco});
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", {64'b0, ov}, {64'b0, eov});
`endif
        @(negedge clk);
        get(w, bsy, dn, s, co, ov);
        chk("done_pulse", {64'b0, dn}, 65'd0);
        chk("sum_hold", {1'b0, s}, {1'b0, es});
    endtask

    initial begin
        logic bsy, dn, co, ov;
        logic [63:0] s;
        int first_done, second_done, ndone;

        rst_n = 1'b1;
        drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(2, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(64, 1'b0, 64'd0, 64'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        get(8, bsy, dn, s, co, ov);
        chk("rst_busy", {64'b0, bsy}, 65'd0);
        chk("rst_done", {64'b0, dn}, 65'd0);
        chk("rst_sum", {1'b0, s}, 65'd0);
        chk("rst_cout", {64'b0, co}, 65'd0);
        chk("rst_ovf", {64'b0, ov}, 65'd0);
        get(64, bsy, dn, s, co, ov);
        chk("rst_sum64", {1'b0, s}, 65'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        op(8, 64'h35, 64'h4A, 1'b0, 1'b0);
        op(8, 64'hFF, 64'h01, 1'b1, 1'b0);
        op(8, 64'h7F, 64'h01, 1'b0, 1'b0);
        op(8, 64'h80, 64'h80, 1'b0, 1'b0);
        op(8, 64'h10, 64'h20, 1'b0, 1'b1);
        op(2, 64'h3, 64'h3, 1'b1, 1'b0);
        op(64, '1, '1, 1'b1, 1'b0);

        // start held high: two back-to-back operations with no idle cycle
        @(negedge clk);
        drive(8, 1'b1, 64'd1, 64'd1, 1'b0);
        @(posedge clk);
        first_done = -1;
        second_done = -1;
        ndone = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) drive(8, 1'b1, 64'd2, 64'd2, 1'b0);
            get(8, bsy, dn, s, co, ov);
            if (first_done < 0 || second_done < 0)
                chk("b2b_busy", {64'b0, bsy}, {64'b0, ~dn});
            if (dn) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = c;
                    chk("b2b_sum1", {1'b0, s}, 65'h02);
                end else if (second_done < 0) begin
                    second_done = c;
                    chk("b2b_sum2", {1'b0, s}, 65'h04);
                end
            end
            if (first_done >= 0 && c == first_done + 1) drive(8, 1'b0, 64'd2, 64'd2, 1'b0);
            @(posedge clk);
        end
        chk("b2b_first", 65'(first_done), 65'd8);
        chk("b2b_gap", 65'(second_done - first_done), 65'd9);
        chk("b2b_count", 65'(ndone), 65'd2);

        // Reset asserted in the middle of a run
        @(negedge clk);
        drive(8, 1'b1, 64'hAA, 64'h33, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 64'hAA, 64'h33, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        get(8, bsy, dn, s, co, ov);
        chk("mid_rst_busy", {64'b0, bsy}, 65'd0);
        chk("mid_rst_sum", {1'b0, s}, 65'd0);
        chk("mid_rst_cout", {64'b0, co}, 65'd0);
        chk("mid_rst_ovf", {64'b0, ov}, 65'd0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("mid_rst_nodone", 65'(ndone), 65'd0);
        op(8, 64'h0F, 64'h01, 1'b0, 1'b0);

        // Randomized operations against the reference
        for (int i = 0; i < 20; i++)
            op(8, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        for (int i = 0; i < 4; i++)
            op(2, 64'($urandom), 64'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < 4; i++)
            op(64, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial adder sequencer: accepts two WIDTH-bit operands and a carry-in, then drives one shared 1-bit full-adder cell over WIDTH clock cycles, LSB first, with a registered carry. It presents the result with a start/busy/done handshake. The adder family uses it where area matters more than latency, in place of a WIDTH-wide ripple chain.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  final carry-out; held with sum.
- ovf  output  1  signed overflow; present only under SERIAL_ADD_OVF_EN.

## Operation
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, cout = 0, ovf = 0
  - operand shift registers = 0, carry register = 0, bit counter = 0
- States:
  - IDLE: if start = 1, capture a, b and cin, clear the counter, go to RUN. Otherwise stay in IDLE.
  - RUN: every cycle, feed the LSBs of the A and B shift registers and the carry register into the bit cell.
    - Shift the cell's sum bit into the MSB of the sum register; shift both operand registers right by one.
    - Load the carry register from the cell carry-out and increment the counter.
    - When the counter reaches WIDTH-1, this is the last bit: load cout from the cell carry-out and go to DONE.
  - DONE: done = 1 for this cycle only.
    - If start = 1, capture new operands and go to RUN, so back-to-back operations have no idle cycle.
    - Otherwise go to IDLE.
- start in RUN is ignored. It is not queued.
- Arithmetic: {cout, sum} = a + b + cin, unsigned, exact for every WIDTH. No truncation beyond WIDTH+1 bits.
- Bit counter width is $clog2(WIDTH). The counter never wraps inside an operation.
- Changes on a, b or cin after the capture edge have no effect on the operation in flight.
- Reset asserted mid-RUN: all state returns to reset values immediately, the partial result is discarded, and no done pulse is produced.

## Timing
- Let E0 be the edge that accepts start.
- busy = 1 from E0 through edge E_WIDTH.
- Bit i is computed in the cycle between E_i and E_(i+1), for i = 0..WIDTH-1.
- State is DONE after edge E_WIDTH. done, sum, cout and ovf are valid in that cycle.
- Latency from start capture to done is WIDTH cycles.
- Throughput is one operation per WIDTH+1 cycles when start is held high.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - ovf port exists.
  - On the last RUN cycle, ovf is registered as (carry into MSB) XOR (carry out of MSB).
  - ovf is valid with done and held with sum; reset value is 0.
- Undefined: the ovf port, its register and its logic are absent. All other behaviour is identical.

## Structure
- Shared package adder_pkg holds:
  - state typedef serial_add_state_t with encodings IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
  - constants SERIAL_ADD_WIDTH_DEF = 8 and SERIAL_ADD_WIDTH_MAX = 64.
- One sub-module: the team's existing 1-bit full-adder cell f_adder1, instantiated exactly once as the shared bit datapath.
- FSM, counter, shift registers and carry register live in serial_add_seq.

## Test plan
- WIDTH=8, a=8'h35, b=8'h4A, cin=0 -> done exactly 8 cycles after the capture edge; sum=8'h7F, cout=0, ovf=0.
- WIDTH=8, a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0. With the macro defined: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, ovf=1.
- Capture a=8'h10, b=8'h20; pulse start again and change a/b during RUN -> second start ignored; result is sum=8'h30, cout=0.
- start held high, with a=1, b=1 then a=2, b=2 -> done pulses 9 cycles apart; sums 8'h02 then 8'h04; busy low only in the DONE cycles.
- Assert rst_n=0 on cycle 4 of RUN -> all outputs 0 immediately; no done. After release, a=8'h0F, b=8'h01 -> sum=8'h10.
- WIDTH=2 and WIDTH=64 with all-ones operands and cin=1 -> sum = all ones, cout=1; latency equals WIDTH.
